// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer.
// DRAIN is only encoded when FETCH_REDIRECT_EN is defined.
package fetch_pkg;

    localparam int ADDR_W  = 16;
    localparam int INSTR_W = 16;

    localparam logic [3:0] OP_JMP = 4'hF;
    localparam logic [3:0] OP_BRF = 4'hE;

    typedef enum logic [1:0] {
        START = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2
`ifdef FETCH_REDIRECT_EN
        ,
        DRAIN = 2'd3
`endif
    } fetch_state_t;

endpackage

// File: rtl/fetch_branch_decode.sv
// Combinational decode of JMP/BRF words returned by memory.
// Jump targets stay inside the current 4K page of the PC.
module fetch_branch_decode
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = fetch_pkg::ADDR_W,
    parameter int INSTR_W = fetch_pkg::INSTR_W
) (
    input  logic [INSTR_W-1:0] MemData,
    input  logic [ADDR_W-1:0]  PcValue,
    output logic               is_jmp,
    output logic               is_brf,
    output logic [ADDR_W-1:0]  jmp_target,
    output logic [8:0]         offset
);

    logic unused_pc_low;

    assign is_jmp     = MemData[INSTR_W-1 -: 4] == OP_JMP;
    assign is_brf     = MemData[INSTR_W-1 -: 4] == OP_BRF;
    assign jmp_target = {PcValue[ADDR_W-1:12], MemData[11:0]};
    assign offset     = {1'b0, MemData[7:0]};

    assign unused_pc_low = ^PcValue[11:0];

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: drives PC load/offset, memory req/ack and issue handshake.
// Define FETCH_REDIRECT_EN to add execute-stage redirects and the DRAIN state.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = fetch_pkg::ADDR_W,
    parameter int INSTR_W = fetch_pkg::INSTR_W
) (
    input  logic               Clock,
    input  logic               nReset,
    input  logic [ADDR_W-1:0]  PcValue,
    output logic               PcLoadEnable,
    output logic [ADDR_W-1:0]  PcLoadValue,
    output logic               PcOffsetEnable,
    output logic [8:0]         PcOffset,
    output logic               MemReq,
    output logic [ADDR_W-1:0]  MemAddr,
    input  logic               MemAck,
    input  logic [INSTR_W-1:0] MemData,
`ifdef FETCH_REDIRECT_EN
    input  logic               RedirectValid,
    input  logic [ADDR_W-1:0]  RedirectTarget,
`endif
    output logic               InstrValid,
    input  logic               InstrReady,
    output logic [INSTR_W-1:0] Instr,
    output logic [ADDR_W-1:0]  InstrAddr
);

    fetch_state_t state, state_nxt;

    logic              is_jmp;
    logic              is_brf;
    logic [ADDR_W-1:0] jmp_target;
    logic [8:0]        br_off;
    logic              redir;
    logic [ADDR_W-1:0] redir_tgt;
    logic              ack_fetch;
    logic              fire;

    fetch_branch_decode #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_dec (
        .MemData    (MemData),
        .PcValue    (PcValue),
        .is_jmp     (is_jmp),
        .is_brf     (is_brf),
        .jmp_target (jmp_target),
        .offset     (br_off)
    );

    assign fire      = InstrValid && InstrReady;
    assign ack_fetch = (state == FETCH) && MemAck;

`ifdef FETCH_REDIRECT_EN
    logic [ADDR_W-1:0] addr_q;

    assign redir     = RedirectValid;
    assign redir_tgt = RedirectTarget;
    assign MemReq    = (state == FETCH) || (state == DRAIN);
    // PC already points at the redirect target while the old request drains
    assign MemAddr   = (state == DRAIN) ? addr_q : PcValue;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            addr_q <= '0;
        end else if (state == FETCH) begin
            addr_q <= PcValue;
        end
    end
`else
    assign redir     = 1'b0;
    assign redir_tgt = '0;
    assign MemReq    = state == FETCH;
    assign MemAddr   = PcValue;
`endif

    always_comb begin
        PcLoadEnable   = 1'b1;
        PcLoadValue    = PcValue;
        PcOffsetEnable = 1'b0;
        PcOffset       = br_off;
        if (redir) begin
            PcLoadValue = redir_tgt;
        end else if (ack_fetch) begin
            if (is_jmp) begin
                PcLoadValue = jmp_target;
            end else if (is_brf) begin
                PcLoadEnable   = 1'b0;
                PcOffsetEnable = 1'b1;
            end else begin
                PcLoadEnable = 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            START: state_nxt = FETCH;
            FETCH: begin
                if (MemAck) begin
                    state_nxt = redir ? FETCH : ISSUE;
                end
`ifdef FETCH_REDIRECT_EN
                else if (redir) begin
                    state_nxt = DRAIN;
                end
`endif
            end
            ISSUE: begin
                if (fire || redir) begin
                    state_nxt = FETCH;
                end
            end
`ifdef FETCH_REDIRECT_EN
            DRAIN: begin
                if (MemAck) begin
                    state_nxt = FETCH;
                end
            end
`endif
            default: state_nxt = START;
        endcase
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state      <= START;
            InstrValid <= 1'b0;
            Instr      <= '0;
            InstrAddr  <= '0;
        end else begin
            state <= state_nxt;
            if (ack_fetch && !redir) begin
                InstrValid <= 1'b1;
                Instr      <= MemData;
                InstrAddr  <= PcValue;
            end else if ((state == ISSUE) && (fire || redir)) begin
                InstrValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: PC and memory models, directed cases, random run.
// Redirect cases are compiled only with FETCH_REDIRECT_EN.
module tb_fetch_sequencer;

    logic        Clock = 1'b0;
    logic        nReset = 1'b0;
    logic [15:0] PcValue;
    logic        PcLoadEnable;
    logic [15:0] PcLoadValue;
    logic        PcOffsetEnable;
    logic [8:0]  PcOffset;
    logic        MemReq;
    logic [15:0] MemAddr;
    logic        MemAck = 1'b0;
    logic [15:0] MemData = 16'h0;
    logic        RedirectValid = 1'b0;
    logic [15:0] RedirectTarget = 16'h0;
    logic        InstrValid;
    logic        InstrReady = 1'b0;
    logic [15:0] Instr;
    logic [15:0] InstrAddr;

    logic [15:0] mem [0:65535];
    logic [15:0] rst_vec = 16'h0;
    logic [15:0] exp_pc = 16'h0;
    int          total = 0;
    int          bad = 0;
    int          issued = 0;
    int          lat_lo = 0;
    int          lat_hi = 0;
    bit          m_busy = 1'b0;
    int          m_cnt = 0;
    int          m_lat = 0;
    logic [15:0] m_addr = 16'h0;

    fetch_sequencer dut (
        .Clock          (Clock),
        .nReset         (nReset),
        .PcValue        (PcValue),
        .PcLoadEnable   (PcLoadEnable),
        .PcLoadValue    (PcLoadValue),
        .PcOffsetEnable (PcOffsetEnable),
        .PcOffset       (PcOffset),
        .MemReq         (MemReq),
        .MemAddr        (MemAddr),
        .MemAck         (MemAck),
        .MemData        (MemData),
`ifdef FETCH_REDIRECT_EN
        .RedirectValid  (RedirectValid),
        .RedirectTarget (RedirectTarget),
`endif
        .InstrValid     (InstrValid),
        .InstrReady     (InstrReady),
        .Instr          (Instr),
        .InstrAddr      (InstrAddr)
    );

    always #5 Clock = ~Clock;

    // program counter the sequencer controls
    always @(posedge Clock or negedge nReset) begin
        if (!nReset)
            PcValue <= rst_vec;
        else if (PcLoadEnable)
            PcValue <= PcLoadValue;
        else if (PcOffsetEnable)
            PcValue <= PcValue + {7'b0, PcOffset};
        else
            PcValue <= PcValue + 16'd1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    function automatic logic [15:0] next_pc(input logic [15:0] a,
                                            input logic [15:0] d);
        case (d[15:12])
            4'hF:    return {a[15:12], d[11:0]};
            4'hE:    return a + {8'h0, d[7:0]};
            default: return a + 16'd1;
        endcase
    endfunction

    function automatic logic [15:0] gen_word();
        int k;
        k = $urandom_range(7, 0);
        if (k == 0) return {4'hF, 12'($urandom)};
        if (k == 1) return {4'hE, 12'($urandom)};
        return {4'($urandom_range(13, 0)), 12'($urandom)};
    endfunction

    task automatic tick();
        @(posedge Clock);
        #2;
    endtask

    task automatic do_reset(input logic [15:0] vec);
        rst_vec = vec;
        nReset = 1'b0;
        RedirectValid = 1'b0;
        InstrReady = 1'b0;
        tick();
        chk("rst_valid", 32'(InstrValid), 32'd0);
        chk("rst_instr", 32'(Instr), 32'd0);
        chk("rst_iaddr", 32'(InstrAddr), 32'd0);
        chk("rst_memreq", 32'(MemReq), 32'd0);
    endtask

    // memory: ack after 0..N idle request cycles, one-cycle pulse
    initial begin
        forever begin
            @(posedge Clock);
            #1;
            if (!nReset || MemAck) m_busy = 1'b0;
            MemAck = 1'b0;
            if (nReset && MemReq) begin
                if (!m_busy) begin
                    m_busy = 1'b1;
                    m_cnt = 0;
                    m_lat = $urandom_range(lat_hi, lat_lo);
                    m_addr = MemAddr;
                end else begin
                    chk("memaddr_stable", 32'(MemAddr), 32'(m_addr));
                end
                if (m_cnt == m_lat) begin
                    MemAck = 1'b1;
                    MemData = mem[MemAddr];
                end else begin
                    m_cnt++;
                end
            end else begin
                m_busy = 1'b0;
            end
        end
    end

    // scoreboard: issued words must follow the program's control flow
    initial begin
        forever begin
            @(negedge Clock);
            if (!nReset) begin
                exp_pc = rst_vec;
            end else begin
                if (InstrValid) begin
                    chk("sb_addr", 32'(InstrAddr), 32'(exp_pc));
                    chk("sb_instr", 32'(Instr), 32'(mem[exp_pc]));
                    if (InstrReady) begin
                        exp_pc = next_pc(exp_pc, mem[exp_pc]);
                        issued++;
                    end
                end
                if (RedirectValid) exp_pc = RedirectTarget;
            end
        end
    end

    initial begin
        bit seen;
        for (int i = 0; i < 65536; i++) mem[i] = gen_word();

        // zero-wait fetch from reset
        do_reset(16'h0000);
        mem[16'h0000] = 16'h1234;
        mem[16'h0001] = 16'h2222;
        InstrReady = 1'b1;
        nReset = 1'b1;
        chk("t1_memreq_c0", 32'(MemReq), 32'd0);
        tick();
        chk("t1_memreq_c1", 32'(MemReq), 32'd1);
        chk("t1_memaddr_c1", 32'(MemAddr), 32'h0000);
        tick();
        chk("t1_valid", 32'(InstrValid), 32'd1);
        chk("t1_instr", 32'(Instr), 32'h1234);
        chk("t1_iaddr", 32'(InstrAddr), 32'h0000);
        tick();
        chk("t1_next_addr", 32'(MemAddr), 32'h0001);

        // JMP
        do_reset(16'h3010);
        mem[16'h3010] = 16'hF0A5;
        InstrReady = 1'b1;
        nReset = 1'b1;
        tick();
        chk("t2_load_en", 32'(PcLoadEnable), 32'd1);
        chk("t2_load_val", 32'(PcLoadValue), 32'h30A5);
        tick();
        chk("t2_pc", 32'(PcValue), 32'h30A5);
        tick();
        chk("t2_next_addr", 32'(MemAddr), 32'h30A5);

        // forward branch
        do_reset(16'h0100);
        mem[16'h0100] = 16'hE010;
        InstrReady = 1'b1;
        nReset = 1'b1;
        tick();
        chk("t3_off_en", 32'(PcOffsetEnable), 32'd1);
        chk("t3_load_en", 32'(PcLoadEnable), 32'd0);
        chk("t3_offset", 32'(PcOffset), 32'h010);
        tick();
        tick();
        chk("t3_next_addr", 32'(MemAddr), 32'h0110);

        // downstream stall
        do_reset(16'h0200);
        mem[16'h0200] = 16'h1111;
        nReset = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("t4_valid", 32'(InstrValid), 32'd1);
            chk("t4_instr", 32'(Instr), 32'h1111);
            chk("t4_iaddr", 32'(InstrAddr), 32'h0200);
            chk("t4_pc", 32'(PcValue), 32'h0201);
            chk("t4_memreq", 32'(MemReq), 32'd0);
            if (i < 4) tick();
        end
        InstrReady = 1'b1;
        tick();
        chk("t4_valid_clr", 32'(InstrValid), 32'd0);
        chk("t4_memreq_on", 32'(MemReq), 32'd1);
        chk("t4_next_addr", 32'(MemAddr), 32'h0201);

`ifdef FETCH_REDIRECT_EN
        // redirect while a slow request is pending
        do_reset(16'h0004);
        lat_lo = 3;
        lat_hi = 3;
        InstrReady = 1'b1;
        nReset = 1'b1;
        tick();
        RedirectValid = 1'b1;
        RedirectTarget = 16'h0800;
        tick();
        RedirectValid = 1'b0;
        chk("t5_pc", 32'(PcValue), 32'h0800);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("t5_drain_addr", 32'(MemAddr), 32'h0004);
            chk("t5_drain_req", 32'(MemReq), 32'd1);
            chk("t5_no_valid", 32'(InstrValid), 32'd0);
            if (MemAck) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk("t5_ack_seen", 32'(seen), 32'd1);
        tick();
        chk("t5_discard", 32'(InstrValid), 32'd0);
        chk("t5_next_addr", 32'(MemAddr), 32'h0800);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (InstrValid) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk("t5_target_issued", 32'(seen), 32'd1);
        chk("t5_target_iaddr", 32'(InstrAddr), 32'h0800);

        // redirect colliding with an acked JMP
        do_reset(16'h0040);
        mem[16'h0040] = 16'hF123;
        lat_lo = 0;
        lat_hi = 0;
        InstrReady = 1'b1;
        nReset = 1'b1;
        tick();
        chk("t6_ack", 32'(MemAck), 32'd1);
        RedirectValid = 1'b1;
        RedirectTarget = 16'h0A00;
        #1;
        chk("t6_load_val", 32'(PcLoadValue), 32'h0A00);
        tick();
        RedirectValid = 1'b0;
        chk("t6_pc", 32'(PcValue), 32'h0A00);
        chk("t6_no_valid", 32'(InstrValid), 32'd0);
        chk("t6_addr", 32'(MemAddr), 32'h0A00);
`endif

        // random programs, latencies, stalls and a mid-run reset
        do_reset(16'($urandom));
        lat_lo = 0;
        lat_hi = 3;
        nReset = 1'b1;
        issued = 0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            InstrReady = $urandom_range(3, 0) != 0;
`ifdef FETCH_REDIRECT_EN
            RedirectValid = $urandom_range(24, 0) == 0;
            RedirectTarget = 16'($urandom);
`endif
            if (c == 1500) begin
                do_reset(16'($urandom));
                nReset = 1'b1;
            end
        end
        RedirectValid = 1'b0;
        InstrReady = 1'b1;
        tick();
        tick();
        chk("rand_progress", 32'(issued >= 200), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction fetch sequencer that drives the 16-bit program counter's control inputs. It reads instruction words from memory at the current PC value through a req/ack port and presents each word downstream through a valid/ready handshake. It decodes unconditional jumps and forward branches and turns them into PC load or offset commands. When the PC must not advance, it holds the PC by reloading the PC's current value.

## Interface
Parameters:
- ADDR_W, 16, address and PC width
- INSTR_W, 16, instruction width

Ports:
- Clock  in  1  single clock; all state changes on the rising edge
- nReset  in  1  asynchronous, active-low reset
- PcValue  in  16  current PC output
- PcLoadEnable  out  1  PC load command
- PcLoadValue  out  16  PC load value
- PcOffsetEnable  out  1  PC offset command
- PcOffset  out  9  PC offset; bit 8 is always 0
- MemReq  out  1  read request
- MemAddr  out  16  read address
- MemAck  in  1  one-cycle pulse; MemData is valid in that cycle
- MemData  in  16  instruction word
- InstrValid  out  1  Instr/InstrAddr valid
- InstrReady  in  1  downstream accept
- Instr  out  16  instruction word
- InstrAddr  out  16  address of Instr
- RedirectValid  in  1  execute-stage redirect (only with FETCH_REDIRECT_EN)
- RedirectTarget  in  16  redirect address (only with FETCH_REDIRECT_EN)

## Operation
States: START, FETCH, ISSUE, DRAIN.

PC control default (hold):
- PcLoadEnable=1, PcLoadValue=PcValue, PcOffsetEnable=0.
- Hold applies in every state and cycle except the cases listed below.

START:
- MemReq=0.
- Next state is FETCH.

FETCH:
- MemReq=1, MemAddr=PcValue; PC held, so the address is stable.
- AddrReg captures PcValue every cycle.
- On MemAck: register Instr=MemData, InstrAddr=PcValue, InstrValid=1, then go to ISSUE.
- PC command in the MemAck cycle, decoded from MemData:
  - MemData[15:12]=4'hF (JMP): load {PcValue[15:12], MemData[11:0]}.
  - MemData[15:12]=4'hE (BRF): PcOffsetEnable=1, PcLoadEnable=0, PcOffset={1'b0, MemData[7:0]}, giving target = branch address + 0..255.
  - Any other opcode: both enables 0, so the PC increments by 1.

ISSUE:
- PC held.
- On InstrValid&&InstrReady: InstrValid clears at the next edge and the state goes to FETCH.

Redirect (FETCH_REDIRECT_EN only; highest priority in every state):
- PC loads RedirectTarget; this overrides the JMP/BRF command.
- In ISSUE: InstrValid clears and the state goes to FETCH. A handshake in the same cycle still counts as consumed.
- In FETCH without MemAck: go to DRAIN.
- In FETCH with MemAck: the word is discarded (InstrValid stays 0) and the state goes to FETCH.
- In DRAIN: MemReq=1, MemAddr=AddrReg. On MemAck the data is discarded and the state goes to FETCH. A further redirect reloads the PC and the state stays DRAIN.

## Timing
- Reset values: state START, InstrValid=0, Instr=0, InstrAddr=0, AddrReg=0, MemReq=0.
- MemReq stays high until MemAck. MemAddr is stable while MemReq=1.
- Zero-wait memory (MemAck in the first FETCH cycle): 1 instruction per 2 cycles when InstrReady=1.
- Instr/InstrAddr are valid the cycle after MemAck and stable while InstrValid=1 and InstrReady=0.
- A redirect takes effect at the next edge; the first request to the target is issued in the cycle after.
- nReset asserted mid-fetch discards the outstanding request. The memory system shares the reset.

## Configuration
- FETCH_REDIRECT_EN defined: RedirectValid/RedirectTarget ports, DRAIN state and AddrReg logic are present.
- FETCH_REDIRECT_EN undefined: those ports and logic are absent, DRAIN is not encoded, and MemAddr=PcValue always.

## Structure
- fetch_pkg contains:
  - the fetch_state_t enum (START, FETCH, ISSUE, DRAIN);
  - OP_JMP=4'hF and OP_BRF=4'hE;
  - ADDR_W and INSTR_W defaults.
- Sub-module fetch_branch_decode: combinational. Inputs MemData and PcValue; outputs is_jmp, is_brf, jump target, offset.

## Test plan
- Reset release, zero-wait memory returns 16'h1234 at address 0, InstrReady=1 → MemReq in cycle 1, Instr=16'h1234 and InstrAddr=0, next MemAddr=1.
- Word 16'hF0A5 fetched at 16'h3010 → PC loads 16'h30A5; next MemAddr=16'h30A5.
- Word 16'hE010 fetched at 16'h0100 → PcOffsetEnable=1, PcOffset=9'h010; next MemAddr=16'h0110.
- InstrReady=0 for 5 cycles after issue → InstrValid/Instr/InstrAddr stable, PcValue unchanged, MemReq=0 until the handshake.
- FETCH_REDIRECT_EN: redirect to 16'h0800 while a 3-cycle-latency request to 16'h0004 is pending → MemAddr stays 16'h0004 until MemAck, that data is never issued, next MemAddr=16'h0800.
- Redirect in the same cycle as MemAck carrying a JMP → PC=RedirectTarget, InstrValid stays 0.
